lmsm_sequencer: RTL and testbench

LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

---
 rtl/lmsm_sequencer_if.sv | 34 +++
 rtl/lmsm_sequencer.sv | 88 ++++++++
 tb/tb_lmsm_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lmsm_sequencer_if.sv
// lmsm_sequencer_if: instruction offer and micro-op handshake bundle for the
// load/store-multiple sequencer; master is the pipeline side, slave the sequencer.
interface lmsm_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int RIDX_W = $clog2(NREGS)
);
    logic              in_valid;
    logic              in_ready;
    logic              is_lm;
    logic              is_sm;
    logic [NREGS-1:0]  reg_mask;
    logic [DATA_W-1:0] base_addr;
    logic              flush;
    logic              uop_valid;
    logic              uop_ready;
    logic              uop_load;
    logic              uop_store;
    logic [RIDX_W-1:0] uop_reg;
    logic [DATA_W-1:0] uop_addr;
    logic              uop_last;
    logic              busy;
    logic              err;

    modport master (
        output in_valid, is_lm, is_sm, reg_mask, base_addr, flush, uop_ready,
        input  in_ready, uop_valid, uop_load, uop_store, uop_reg, uop_addr, uop_last, busy, err
    );

    modport slave (
        input  in_valid, is_lm, is_sm, reg_mask, base_addr, flush, uop_ready,
        output in_ready, uop_valid, uop_load, uop_store, uop_reg, uop_addr, uop_last, busy, err
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands a load/store-multiple instruction into one micro-op per
// set mask bit, lowest register first, at consecutive ADDR_STEP-spaced addresses.
module lmsm_sequencer #(
    parameter int DATA_W    = 16,
    parameter int NREGS     = 8,
    parameter int ADDR_STEP = 1
) (
    input logic             clk,
    input logic             rst_n,
    lmsm_sequencer_if.slave bus
);
    localparam int RIDX_W = $clog2(NREGS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [NREGS-1:0]  mask_q, mask_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [RIDX_W-1:0] reg_q, reg_d;
    logic              load_q, load_d;
    logic              store_q, store_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic              kind_ok, accept, legal, illegal, hs;

    assign bus.in_ready  = (state_q == IDLE) & ~bus.flush;
    assign bus.uop_valid = state_q == RUN;
    assign bus.busy      = state_q == RUN;
    assign bus.uop_load  = load_q;
    assign bus.uop_store = store_q;
    assign bus.uop_reg   = reg_q;
    assign bus.uop_addr  = addr_q;
    assign bus.uop_last  = last_q;
    assign bus.err       = err_q;

    always_comb begin
        kind_ok = bus.is_lm ^ bus.is_sm;
        accept  = bus.in_valid & bus.in_ready;
        legal   = accept & kind_ok & (|bus.reg_mask);
        illegal = accept & ((bus.is_lm & bus.is_sm) | (kind_ok & ~(|bus.reg_mask)));
        hs      = (state_q == RUN) & bus.uop_ready;
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        if (bus.flush) begin
            state_d = IDLE;
            mask_d  = '0;
        end else if (legal) begin
            state_d = RUN;
            mask_d  = bus.reg_mask;
            addr_d  = bus.base_addr;
        end else if (hs) begin
            mask_d  = mask_q & (mask_q - NREGS'(1));
            addr_d  = addr_q + DATA_W'(ADDR_STEP);
            state_d = last_q ? IDLE : RUN;
        end
        load_d  = (state_d == RUN) & (legal ? bus.is_lm : load_q);
        store_d = (state_d == RUN) & (legal ? bus.is_sm : store_q);
        // Descending scan leaves the lowest set bit's index.
        reg_d = '0;
        for (int i = NREGS - 1; i >= 0; i--)
            if (mask_d[i]) reg_d = RIDX_W'(i);
        last_d = (|mask_d) & ~(|(mask_d & (mask_d - NREGS'(1))));
        err_d  = illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            reg_q   <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            load_q  <= load_d;
            store_q <= store_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: random and directed LM/SM stimulus checked against a
// queue of expected micro-ops expanded directly from each accepted mask.
module tb_lmsm_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_b_n = 1'b0;
    always #5 clk = ~clk;

    lmsm_sequencer_if #(.DATA_W(16), .NREGS(8))  bus ();
    lmsm_sequencer_if #(.DATA_W(16), .NREGS(16)) bus_b ();

    lmsm_sequencer #(.DATA_W(16), .NREGS(8), .ADDR_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    lmsm_sequencer #(.DATA_W(16), .NREGS(16), .ADDR_STEP(2)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .bus(bus_b)
    );

    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] a;
        logic        last;
        logic        ld;
    } uop_t;

    uop_t exp_q[$];
    logic err_exp = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic expand(input logic lm, input logic [7:0] m, input logic [15:0] b);
        int   n;
        int   k;
        uop_t u;
        n = $countones(m);
        k = 0;
        for (int i = 0; i < 8; i++)
            if (m[i]) begin
                u.r    = 3'(i);
                u.a    = b + 16'(k);
                u.last = (k == n - 1);
                u.ld   = lm;
                exp_q.push_back(u);
                k++;
            end
    endtask

    task automatic check_outs();
        uop_t f;
        check("uop_valid", bus.uop_valid, exp_q.size() != 0);
        check("busy", bus.busy, exp_q.size() != 0);
        check("err", bus.err, err_exp);
        if (exp_q.size() != 0) begin
            f = exp_q[0];
            check("uop_reg", bus.uop_reg, f.r);
            check("uop_addr", bus.uop_addr, f.a);
            check("uop_last", bus.uop_last, f.last);
            check("uop_load", bus.uop_load, f.ld);
            check("uop_store", bus.uop_store, !f.ld);
        end
    endtask

    task automatic cyc(input logic v, input logic lm, input logic sm, input logic [7:0] m,
                       input logic [15:0] b, input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.is_lm     = lm;
        bus.is_sm     = sm;
        bus.reg_mask  = m;
        bus.base_addr = b;
        bus.uop_ready = rdy;
        bus.flush     = fl;
        #1;
        check("in_ready", bus.in_ready, exp_q.size() == 0 && !fl);
        err_exp = 1'b0;
        if (fl) exp_q.delete();
        else if (exp_q.size() != 0) begin
            if (rdy) void'(exp_q.pop_front());
        end else if (v) begin
            if ((lm && sm) || ((lm || sm) && m == 8'h00)) err_exp = 1'b1;
            else if (lm || sm) expand(lm, m, b);
        end
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 24 && exp_q.size() != 0; i++) idle(1'b1);
        idle(1'b1);
    endtask

    initial begin
        bus.in_valid = 0; bus.is_lm = 0; bus.is_sm = 0; bus.reg_mask = '0;
        bus.base_addr = '0; bus.flush = 0; bus.uop_ready = 0;
        bus_b.in_valid = 0; bus_b.is_lm = 0; bus_b.is_sm = 0; bus_b.reg_mask = '0;
        bus_b.base_addr = '0; bus_b.flush = 0; bus_b.uop_ready = 0;
        #2;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_outs", {bus.uop_valid, bus.uop_load, bus.uop_store, bus.uop_reg,
                           bus.uop_addr, bus.uop_last, bus.busy, bus.err}, 0);
        #6 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 1, 0, 8'hA5, 16'h0010, 1, 0);
        drain();
        cyc(1, 0, 1, 8'h80, 16'hFFFF, 1, 0);
        drain();
        cyc(1, 0, 1, 8'hFF, 16'hFFFE, 1, 0);
        drain();
        cyc(1, 1, 0, 8'h00, 16'h1234, 1, 0);
        idle(1);
        cyc(1, 1, 1, 8'h3C, 16'h1234, 1, 0);
        idle(1);
        cyc(1, 0, 0, 8'h3C, 16'h1234, 1, 0);
        idle(1);
        cyc(1, 1, 0, 8'h0F, 16'h0200, 1, 0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle((i % 4 == 0) || (i % 4 == 3));
        idle(1);
        cyc(1, 1, 0, 8'hFF, 16'h0300, 1, 0);
        idle(1);
        idle(1);
        cyc(0, 0, 0, 8'h00, 16'h0000, 1, 1);
        cyc(1, 1, 0, 8'h06, 16'h0400, 1, 0);
        drain();
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                16'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
        drain();
        cyc(1, 1, 0, 8'hFF, 16'h0500, 1, 0);
        idle(1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_outs", {bus.uop_valid, bus.uop_load, bus.uop_store, bus.uop_reg,
                              bus.uop_addr, bus.uop_last, bus.busy, bus.err}, 0);
        exp_q.delete();
        err_exp = 1'b0;
        #3 rst_n = 1'b1;
        #1 check("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        idle(1);
        #3 rst_b_n = 1'b1;
        @(posedge clk);
        #1;
        bus_b.in_valid = 1; bus_b.is_lm = 1; bus_b.reg_mask = 16'h8001;
        bus_b.base_addr = 16'h0100; bus_b.uop_ready = 1;
        @(posedge clk);
        #1;
        bus_b.in_valid = 0;
        check("b_uop0", {bus_b.uop_valid, bus_b.uop_load, bus_b.uop_reg, bus_b.uop_addr,
                         bus_b.uop_last}, {1'b1, 1'b1, 4'd0, 16'h0100, 1'b0});
        @(posedge clk);
        #1;
        check("b_uop1", {bus_b.uop_valid, bus_b.uop_load, bus_b.uop_reg, bus_b.uop_addr,
                         bus_b.uop_last}, {1'b1, 1'b1, 4'd15, 16'h0102, 1'b1});
        @(posedge clk);
        #1;
        check("b_idle", {bus_b.uop_valid, bus_b.in_ready}, 2'b01);
        bus_b.in_valid = 1; bus_b.reg_mask = 16'hFFFF; bus_b.base_addr = 16'h0000;
        @(posedge clk);
        #1;
        bus_b.in_valid = 0;
        @(posedge clk);
        #1;
        check("b_run", {bus_b.uop_valid, bus_b.uop_reg, bus_b.uop_addr}, {1'b1, 4'd1, 16'h0002});
        rst_b_n = 1'b0;
        #1;
        check("b_rst_outs", {bus_b.uop_valid, bus_b.uop_load, bus_b.uop_store, bus_b.uop_reg,
                             bus_b.uop_addr, bus_b.uop_last, bus_b.busy, bus_b.err}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
